spi_controller: RTL and testbench
=================================

# spi_controller

SPI-mode-0 controller that originates the 16-bit register-write frames accepted by the team's SPI peripheral: one R/W bit, a 7-bit address, then 8 data bits, MSB first. It sits on the test/bring-up side of the design, for example in a loopback harness or a host-side bridge, and converts a valid/ready request into SCLK/nCS/COPI waveforms slow enough for the peripheral's two-flop synchronisers. The block is write-only: there is no CIPO input.

## Interface

- HALF_PERIOD, default 4: clk cycles per SCLK half-period. Legal range 2..255. Use ≥4 when the peripheral runs on the same clk.
- GAP_CYCLES, default 4: minimum idle clk cycles after nCS deasserts before the next request is accepted. Legal range 0..255.

- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  controller idle; a request is accepted when req_valid && req_ready on a clk edge.
- req_rw  input  1  frame bit 15; 1 = write.
- req_addr  input  7  frame bits 14:8.
- req_data  input  8  frame bits 7:0.
- busy  output  1  high from the cycle after acceptance until req_ready reasserts.
- done  output  1  one-cycle pulse in the cycle nCS returns high.
- SCLK  output  1  serial clock, idles low.
- nCS  output  1  chip select, active-low, idles high.
- COPI  output  1  serial data out.

## Operation

- State machine: IDLE → SETUP → SCLK_HI ⇄ SCLK_LO → HOLD → GAP → IDLE.
- IDLE:
  - nCS=1, SCLK=0, COPI=0, req_ready=1, busy=0.
  - On accept, latch shift = {req_rw, req_addr, req_data}, set bit counter to 0 and half-period timer to HALF_PERIOD-1, and go to SETUP.
- SETUP: nCS=0 and COPI=shift[15] for HALF_PERIOD cycles, then go to SCLK_HI.
- SCLK_HI: SCLK=1 for HALF_PERIOD cycles. The peripheral samples COPI on this rising edge. Increment the bit counter on exit.
  - If the count is now 16, go to HOLD.
  - Otherwise go to SCLK_LO, shifting left by one so COPI changes together with the SCLK falling edge.
- SCLK_LO: SCLK=0 for HALF_PERIOD cycles, then go to SCLK_HI.
- HOLD: SCLK=0, nCS=0, COPI holds bit 0 for HALF_PERIOD cycles. Then set nCS=1 and COPI=0, pulse done, and go to GAP.
- GAP: nCS=1 for GAP_CYCLES cycles, then go to IDLE. If GAP_CYCLES=0, go straight to IDLE.
- Each frame produces exactly 16 SCLK rising edges. COPI never changes while SCLK is high.
- Request inputs are ignored outside IDLE. Changing req_* mid-frame has no effect on the frame in progress.
- SCLK, nCS and COPI are driven directly from flops, with no combinational path from any input.
- Reset values: nCS=1, SCLK=0, COPI=0, done=0, busy=0, req_ready=1, state=IDLE, counters=0.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). The peripheral sees nCS rise with fewer than 16 bits and does not commit.

## Timing

- Acceptance edge at cycle T. Let H = HALF_PERIOD.
- Cycle T+1: nCS falls, COPI = bit 15.
- Rising edge k (k = 0..15) occurs at cycle T+1+H+2kH.
- COPI changes to bit 15-k-1 at cycle T+1+2(k+1)H.
- nCS is low for exactly 33H cycles. nCS rises and done pulses at cycle T+1+33H.
- req_ready reasserts at cycle T+1+33H+GAP_CYCLES.
- Minimum nCS-high time between back-to-back frames is GAP_CYCLES+1 cycles.
- Defaults: nCS low 132 cycles, done at T+133, next acceptance at T+137.

## Test plan

- Write frame (defaults): rw=1, addr=0x04, data=0xA5. COPI sampled at the 16 SCLK rises reads 0x84A5. nCS low 132 cycles; done at T+133 for one cycle. Looped to the team's peripheral: pwm_duty_cycle=0xA5, all other registers 0.
- Back-to-back: req_valid held high with addr 0x00/data 0xFF, then addr 0x01/data 0x0F. Second acceptance at T+137; nCS high 5 cycles between frames. Peripheral en_reg_out_7_0=0xFF and en_reg_out_15_8=0x0F.
- Read bit: rw=0, addr=0x02, data=0x55. Normal 16-bit waveform with first COPI bit 0. Peripheral en_reg_pwm_7_0 stays 0x00.
- Mid-frame reset: assert rst_n low after the 7th SCLK rise. nCS=1, SCLK=0, COPI=0 within the same cycle. All peripheral registers unchanged. After release, req_ready=1 and a fresh frame with addr 0x03/data 0x3C lands correctly.
- Input stability: change req_addr/req_data every cycle during a frame. Transmitted bits equal the values latched at acceptance, and busy stays high throughout.
- HALF_PERIOD=2, GAP_CYCLES=0: nCS low 66 cycles, exactly 16 rising edges, req_ready back at T+67.

Source files
------------

// File: rtl/spi_controller_if.sv
// Request/status and SPI pin bundle for spi_controller.
// master = requester side, slave = the controller itself.
interface spi_controller_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_rw;
   logic [6:0] req_addr;
   logic [7:0] req_data;
   logic       busy;
   logic       done;
   logic       SCLK;
   logic       nCS;
   logic       COPI;

   modport master (
      output req_valid, req_rw, req_addr, req_data,
      input  req_ready, busy, done, SCLK, nCS, COPI
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_data,
      output req_ready, busy, done, SCLK, nCS, COPI
   );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 write-frame originator: 16-bit {rw, addr[6:0], data[7:0]}, MSB first.
// All pin and status outputs come straight from flops.
module spi_controller #(
   parameter int HALF_PERIOD = 4,
   parameter int GAP_CYCLES  = 4
) (
   input logic              clk,
   input logic              rst_n,
   spi_controller_if.slave  bus
);
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_SCLK_HI = 3'd2,
      ST_SCLK_LO = 3'd3,
      ST_HOLD    = 3'd4,
      ST_GAP     = 3'd5
   } state_t;

   localparam logic [7:0] HP_M1  = 8'(HALF_PERIOD - 1);
   localparam logic [7:0] GAP_M1 = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
   localparam bit         NO_GAP = (GAP_CYCLES == 0);

   state_t      state_r, state_s;
   logic [7:0]  timer_r, timer_s;
   logic [4:0]  bit_cnt_r, bit_cnt_s;
   logic [15:0] shift_r, shift_s;
   logic        sclk_r, sclk_s;
   logic        ncs_r, ncs_s;
   logic        copi_r, copi_s;
   logic        done_r, done_s;
   logic        ready_r, ready_s;
   logic        busy_r, busy_s;
   logic        tick_s;

   assign tick_s        = (timer_r == 8'd0);
   assign bus.SCLK      = sclk_r;
   assign bus.nCS       = ncs_r;
   assign bus.COPI      = copi_r;
   assign bus.done      = done_r;
   assign bus.req_ready = ready_r;
   assign bus.busy      = busy_r;

   // Next-state and next-output logic; every output is computed here and registered below.
   always_comb begin
      state_s   = state_r;
      timer_s   = timer_r;
      bit_cnt_s = bit_cnt_r;
      shift_s   = shift_r;
      sclk_s    = sclk_r;
      ncs_s     = ncs_r;
      copi_s    = copi_r;
      done_s    = 1'b0;
      ready_s   = ready_r;
      busy_s    = busy_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.req_valid && ready_r) begin
               shift_s   = {bus.req_rw, bus.req_addr, bus.req_data};
               bit_cnt_s = 5'd0;
               timer_s   = HP_M1;
               ncs_s     = 1'b0;
               sclk_s    = 1'b0;
               copi_s    = bus.req_rw;
               ready_s   = 1'b0;
               busy_s    = 1'b1;
               state_s   = ST_SETUP;
            end else begin
               ncs_s   = 1'b1;
               sclk_s  = 1'b0;
               copi_s  = 1'b0;
               ready_s = 1'b1;
               busy_s  = 1'b0;
            end
         end
         ST_SETUP: begin
            if (tick_s) begin
               sclk_s  = 1'b1;
               timer_s = HP_M1;
               state_s = ST_SCLK_HI;
            end else begin
               timer_s = timer_r - 8'd1;
            end
         end
         ST_SCLK_HI: begin
            if (tick_s) begin
               bit_cnt_s = bit_cnt_r + 5'd1;
               sclk_s    = 1'b0;
               timer_s   = HP_M1;
               // Last rising edge done: COPI keeps bit 0 through HOLD.
               if (bit_cnt_r == 5'd15) begin
                  state_s = ST_HOLD;
               end else begin
                  shift_s = {shift_r[14:0], 1'b0};
                  copi_s  = shift_r[14];
                  state_s = ST_SCLK_LO;
               end
            end else begin
               timer_s = timer_r - 8'd1;
            end
         end
         ST_SCLK_LO: begin
            if (tick_s) begin
               sclk_s  = 1'b1;
               timer_s = HP_M1;
               state_s = ST_SCLK_HI;
            end else begin
               timer_s = timer_r - 8'd1;
            end
         end
         ST_HOLD: begin
            if (tick_s) begin
               ncs_s  = 1'b1;
               copi_s = 1'b0;
               done_s = 1'b1;
               if (NO_GAP) begin
                  timer_s = 8'd0;
                  ready_s = 1'b1;
                  busy_s  = 1'b0;
                  state_s = ST_IDLE;
               end else begin
                  timer_s = GAP_M1;
                  state_s = ST_GAP;
               end
            end else begin
               timer_s = timer_r - 8'd1;
            end
         end
         ST_GAP: begin
            if (tick_s) begin
               ready_s = 1'b1;
               busy_s  = 1'b0;
               state_s = ST_IDLE;
            end else begin
               timer_s = timer_r - 8'd1;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            timer_s   = 8'd0;
            bit_cnt_s = 5'd0;
            shift_s   = 16'd0;
            sclk_s    = 1'b0;
            ncs_s     = 1'b1;
            copi_s    = 1'b0;
            ready_s   = 1'b1;
            busy_s    = 1'b0;
         end
      endcase
   end

   // State, counter and output registers with asynchronous return to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         timer_r   <= 8'd0;
         bit_cnt_r <= 5'd0;
         shift_r   <= 16'd0;
         sclk_r    <= 1'b0;
         ncs_r     <= 1'b1;
         copi_r    <= 1'b0;
         done_r    <= 1'b0;
         ready_r   <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         timer_r   <= timer_s;
         bit_cnt_r <= bit_cnt_s;
         shift_r   <= shift_s;
         sclk_r    <= sclk_s;
         ncs_r     <= ncs_s;
         copi_r    <= copi_s;
         done_r    <= done_s;
         ready_r   <= ready_s;
         busy_r    <= busy_s;
      end
   end
endmodule

// File: tb/tb_spi_controller.sv
// Randomised frame-level bench for spi_controller: two instances (H=4/G=4 and H=2/G=0)
// checked against timing and bit-order expectations derived from the frame format.
module tb_spi_controller;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid_s;
   logic       rw_s;
   logic [6:0] addr_s;
   logic [7:0] data_s;
   logic       sel_s;
   int         checks_total  = 0;
   int         checks_passed = 0;
   int         high_run      = 0;

   always #5 clk = ~clk;

   spi_controller_if b0 ();
   spi_controller_if b1 ();

   assign b0.req_valid = valid_s & ~sel_s;
   assign b0.req_rw    = rw_s;
   assign b0.req_addr  = addr_s;
   assign b0.req_data  = data_s;
   assign b1.req_valid = valid_s & sel_s;
   assign b1.req_rw    = rw_s;
   assign b1.req_addr  = addr_s;
   assign b1.req_data  = data_s;

   spi_controller #(.HALF_PERIOD(4), .GAP_CYCLES(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
   spi_controller #(.HALF_PERIOD(2), .GAP_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

   wire mon_ready = sel_s ? b1.req_ready : b0.req_ready;
   wire mon_busy  = sel_s ? b1.busy      : b0.busy;
   wire mon_done  = sel_s ? b1.done      : b0.done;
   wire mon_sclk  = sel_s ? b1.SCLK      : b0.SCLK;
   wire mon_ncs   = sel_s ? b1.nCS       : b0.nCS;
   wire mon_copi  = sel_s ? b1.COPI      : b0.COPI;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      if (obs === exp) checks_passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ncs"},   32'(mon_ncs),   32'd1);
      chk({tag, "_sclk"},  32'(mon_sclk),  32'd0);
      chk({tag, "_copi"},  32'(mon_copi),  32'd0);
      chk({tag, "_done"},  32'(mon_done),  32'd0);
      chk({tag, "_busy"},  32'(mon_busy),  32'd0);
      chk({tag, "_ready"}, 32'(mon_ready), 32'd1);
   endtask

   // Called at a negedge; observes cycle T+idx at the idx-th negedge after acceptance edge T.
   task automatic run_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                            input bit scramble, input bit hold_valid, input bit check_gap);
      int h, g, idx, wait_n, low_cnt, rises, done_cnt, done_idx, ready_idx, first_low;
      int busy_bad, copi_bad, gap;
      logic [15:0] exp_frame, got;
      logic prev_sclk, prev_copi;
      h = sel_s ? 2 : 4;
      g = sel_s ? 0 : 4;
      exp_frame = {rw, addr, data};
      got = 16'd0;
      low_cnt = 0; rises = 0; done_cnt = 0; done_idx = 0; ready_idx = 0; first_low = 0;
      busy_bad = 0; copi_bad = 0; gap = -1;
      wait_n = 0;
      while (!mon_ready && wait_n < 2000) begin
         if (mon_ncs) high_run++;
         @(negedge clk);
         wait_n++;
      end
      chk("ready_wait", 32'(mon_ready), 32'd1);
      rw_s = rw; addr_s = addr; data_s = data; valid_s = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold_valid) valid_s = 1'b0;
      prev_sclk = 1'b0;
      prev_copi = 1'b0;
      for (idx = 1; idx <= 33 * h + g + 20; idx++) begin
         if (!mon_ncs) begin
            low_cnt++;
            if (first_low == 0) begin
               first_low = idx;
               gap = high_run;
            end
            high_run = 0;
         end else begin
            high_run++;
         end
         if (mon_sclk && !prev_sclk) begin
            if (rises < 16) got[15 - rises] = mon_copi;
            rises++;
         end
         if (mon_sclk && prev_sclk && (mon_copi !== prev_copi)) copi_bad++;
         if (mon_done) begin
            done_cnt++;
            done_idx = idx;
         end
         if (mon_ready) begin
            ready_idx = idx;
            break;
         end
         if (!mon_busy) busy_bad++;
         prev_sclk = mon_sclk;
         prev_copi = mon_copi;
         if (scramble) begin
            addr_s = 7'($urandom);
            data_s = 8'($urandom);
            rw_s   = 1'($urandom);
         end
         @(negedge clk);
      end
      chk("first_low",   32'(first_low), 32'd1);
      chk("ncs_low_len", 32'(low_cnt),   32'(33 * h));
      chk("sclk_rises",  32'(rises),     32'd16);
      chk("copi_bits",   32'(got),       32'(exp_frame));
      chk("copi_stable", 32'(copi_bad),  32'd0);
      chk("done_count",  32'(done_cnt),  32'd1);
      chk("done_at",     32'(done_idx),  32'(1 + 33 * h));
      chk("ready_at",    32'(ready_idx), 32'(1 + 33 * h + g));
      chk("busy_held",   32'(busy_bad),  32'd0);
      chk("busy_clear",  32'(mon_busy),  32'd0);
      if (check_gap) chk("ncs_gap", 32'(gap), 32'(g + 1));
   endtask

   initial begin
      rst_n = 1'b0; valid_s = 1'b0; sel_s = 1'b0;
      rw_s = 1'b0; addr_s = 7'd0; data_s = 8'd0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset0");
      sel_s = 1'b1;
      #1;
      chk_idle_outputs("reset1");
      sel_s = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      // Reference write frame, back-to-back pair, read-bit frame.
      run_frame(1'b1, 7'h04, 8'hA5, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      run_frame(1'b1, 7'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
      run_frame(1'b1, 7'h01, 8'h0F, 1'b0, 1'b0, 1'b1);
      run_frame(1'b0, 7'h02, 8'h55, 1'b0, 1'b0, 1'b0);

      // Inputs churn during the frame; random frames.
      for (int i = 0; i < 2; i++)
         run_frame(1'($urandom), 7'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         run_frame(1'($urandom), 7'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);

      // Mid-frame reset after the 7th rising edge.
      begin
         int rises, n;
         logic prev;
         rw_s = 1'b1; addr_s = 7'h06; data_s = 8'hC3; valid_s = 1'b1;
         @(posedge clk);
         @(negedge clk);
         valid_s = 1'b0;
         rises = 0; n = 0; prev = 1'b0;
         while (rises < 7 && n < 500) begin
            if (mon_sclk && !prev) rises++;
            prev = mon_sclk;
            if (rises < 7) begin
               @(negedge clk);
               n++;
            end
         end
         chk("rst_reach7", 32'(rises), 32'd7);
         chk("rst_pre_ncs", 32'(mon_ncs), 32'd0);
         rst_n = 1'b0;
         #1;
         chk_idle_outputs("midrst");
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         chk("post_rst_ready", 32'(mon_ready), 32'd1);
         high_run = 0;
         run_frame(1'b1, 7'h03, 8'h3C, 1'b0, 1'b0, 1'b0);
      end

      // Fast instance: HALF_PERIOD=2, GAP_CYCLES=0, including a back-to-back pair.
      sel_s = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         run_frame(1'($urandom), 7'($urandom), 8'($urandom), i == 1, 1'b0, 1'b0);
      run_frame(1'($urandom), 7'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0);
      run_frame(1'($urandom), 7'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
